// File: rtl/hamming_uart_tx_param.sv
// Hamming(N,DATA_W) encoder feeding a framed, LSB-first UART transmitter; one word in flight.
// Optional overall-parity (SECDED) bit after the codeword when HAMMING_SECDED_EN is defined.
module hamming_uart_tx_param #(
    parameter int DATA_W       = 11,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk_tx,
    input  logic              rst_tx,
    input  logic [DATA_W-1:0] msg_in_tx,
    input  logic              valid_tx,
    output logic              ready_tx,
    output logic              msg_out_tx,
    output logic              busy_tx
);

    // Smallest P with 2^P >= DATA_W + P + 1.
    function automatic int calc_parity_bits(input int dw);
        int p;
        p = 0;
        for (int k = 1; k <= 7; k++) begin
            if (p == 0 && (1 << k) >= dw + k + 1) p = k;
        end
        return p;
    endfunction

    localparam int P      = calc_parity_bits(DATA_W);
    localparam int N      = DATA_W + P;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(N);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef HAMMING_SECDED_EN
        ST_PAR,
`endif
        ST_STOP
    } state_t;

    // Bit i of the result is codeword position i+1; built by shifting so no variable indexing is needed.
    function automatic logic [N-1:0] encode(input logic [DATA_W-1:0] d);
        logic [N-1:0]      cw;
        logic [N-1:0]      mask;
        logic [DATA_W-1:0] rem;
        logic              par;
        cw  = '0;
        rem = d;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                cw = {1'b0, cw[N-1:1]};
            end else begin
                cw  = {rem[0], cw[N-1:1]};
                rem = rem >> 1;
            end
        end
        for (int k = 0; k < P; k++) begin
            mask = '0;
            for (int pos = 1; pos <= N; pos++) begin
                mask = {((pos >> k) & 1) != 0, mask[N-1:1]};
            end
            par = ^(cw & mask);
            cw  = cw | (N'(par) << ((1 << k) - 1));
        end
        return cw;
    endfunction

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [N-1:0]      cw_q, cw_d;
    logic              line_q, line_d;
    logic              bit_done;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        cw_d      = cw_q;
        line_d    = 1'b1;
        bit_done  = (baud_q == BAUD_LAST);

        case (state_q)
            ST_IDLE: begin
                if (valid_tx) begin
                    cw_d      = encode(msg_in_tx);
                    state_d   = ST_START;
                    baud_d    = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    baud_d    = '0;
                    bit_cnt_d = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef HAMMING_SECDED_EN
                        state_d   = ST_PAR;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef HAMMING_SECDED_EN
            ST_PAR: begin
                if (bit_done) begin
                    state_d   = ST_STOP;
                    baud_d    = '0;
                    bit_cnt_d = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                baud_d    = '0;
                bit_cnt_d = '0;
            end
        endcase

        // The line register is loaded from the upcoming state so the start bit shows the cycle after accept.
        case (state_d)
            ST_START: line_d = 1'b0;
            ST_DATA:  line_d = cw_d[bit_cnt_d];
`ifdef HAMMING_SECDED_EN
            ST_PAR:   line_d = ^cw_d;
`endif
            default:  line_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_tx) begin
        if (rst_tx) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            cw_q      <= '0;
            line_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            cw_q      <= cw_d;
            line_q    <= line_d;
        end
    end

    assign ready_tx   = (state_q == ST_IDLE);
    assign busy_tx    = (state_q != ST_IDLE);
    assign msg_out_tx = line_q;

endmodule

// File: tb/tb_hamming_uart_tx_param.sv
// Directed bench for hamming_uart_tx_param: an 11-bit/4-clk/1-stop instance and a 4-bit/1-clk/2-stop instance.
module tb_hamming_uart_tx_param;

    localparam int C11 = 4;
    localparam int N11 = 15;
    localparam int S11 = 1;
    localparam int C4  = 1;
    localparam int N4  = 7;
    localparam int S4  = 2;
`ifdef HAMMING_SECDED_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    logic        clk;
    logic        rst;
    logic [10:0] msg11;
    logic        v11, rdy11, line11, busy11;
    logic [3:0]  msg4;
    logic        v4, rdy4, line4, busy4;

    int total = 0;
    int bad   = 0;

    hamming_uart_tx_param #(.DATA_W(11), .CLKS_PER_BIT(C11), .STOP_BITS(S11)) dut11 (
        .clk_tx     (clk),
        .rst_tx     (rst),
        .msg_in_tx  (msg11),
        .valid_tx   (v11),
        .ready_tx   (rdy11),
        .msg_out_tx (line11),
        .busy_tx    (busy11)
    );

    hamming_uart_tx_param #(.DATA_W(4), .CLKS_PER_BIT(C4), .STOP_BITS(S4)) dut4 (
        .clk_tx     (clk),
        .rst_tx     (rst),
        .msg_in_tx  (msg4),
        .valid_tx   (v4),
        .ready_tx   (rdy4),
        .msg_out_tx (line4),
        .busy_tx    (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference decoder: syndrome is XOR of set positions; data taken from non-power-of-two positions.
    task automatic decode(input logic [14:0] cw, input int n, output int syn, output logic [10:0] d);
        int di;
        syn = 0;
        d   = '0;
        di  = 0;
        for (int pos = 1; pos <= n; pos++) begin
            if (cw[pos-1]) syn = syn ^ pos;
            if ((pos & (pos - 1)) != 0) begin
                d[di] = cw[pos-1];
                di++;
            end
        end
    endtask

    // Caller is at a negedge with the selected DUT idle. Ends at the negedge of the first idle cycle after the frame.
    task automatic run_frame(input bit sel, input logic [10:0] data, input logic [10:0] mid, input bit hold,
                             input logic [14:0] exp_cw, input logic exp_par, input string name);
        int          c, n, s, nbits, syn;
        logic [14:0] rx;
        logic [10:0] dec, want;
        logic        err, ebit, rl, rb, rr;
        c     = sel ? C4 : C11;
        n     = sel ? N4 : N11;
        s     = sel ? S4 : S11;
        nbits = 1 + n + PX + s;
        rx    = '0;
        rl    = 1'b0;
        rb    = 1'b0;
        rr    = 1'b0;

        if (sel) begin msg4 = data[3:0]; v4 = 1'b1; end
        else     begin msg11 = data;     v11 = 1'b1; end
        rr = sel ? rdy4 : rdy11;
        total++;
        if (rr !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, rr);
        end

        @(posedge clk);
        #1;
        if (!hold) begin
            if (sel) v4 = 1'b0; else v11 = 1'b0;
        end

        for (int b = 0; b < nbits; b++) begin
            err = 1'b0;
            if (b == 0)                    ebit = 1'b0;
            else if (b <= n)               ebit = exp_cw[b-1];
            else if (PX == 1 && b == n+1)  ebit = exp_par;
            else                           ebit = 1'b1;
            for (int k = 0; k < c; k++) begin
                @(negedge clk);
                if (b == 2 && k == 0) begin
                    if (sel) msg4 = mid[3:0]; else msg11 = mid;
                end
                rl = sel ? line4 : line11;
                rb = sel ? busy4 : busy11;
                rr = sel ? rdy4  : rdy11;
                if (rl !== ebit || rb !== 1'b1 || rr !== 1'b0) err = 1'b1;
                if (b >= 1 && b <= n) rx[b-1] = rl;
            end
            total++;
            if (err) begin
                bad++;
                $display("FAIL %s frame_bit%0d: line=%b busy=%b ready=%b want line=%b busy=1 ready=0",
                         name, b, rl, rb, rr, ebit);
            end
        end

        @(negedge clk);
        rl = sel ? line4 : line11;
        rb = sel ? busy4 : busy11;
        rr = sel ? rdy4  : rdy11;
        total++;
        if (rl !== 1'b1 || rb !== 1'b0 || rr !== 1'b1) begin
            bad++;
            $display("FAIL %s idle_after_frame: line=%b busy=%b ready=%b want 1 0 1", name, rl, rb, rr);
        end

        decode(rx, n, syn, dec);
        want = sel ? {7'b0, data[3:0]} : data;
        total++;
        if (syn != 0 || dec !== want) begin
            bad++;
            $display("FAIL %s decode: syndrome=%0d data=%h want syndrome=0 data=%h", name, syn, dec, want);
        end
    endtask

    task automatic check_idle(input string name);
        total++;
        if (line11 !== 1'b1 || rdy11 !== 1'b1 || busy11 !== 1'b0 ||
            line4 !== 1'b1 || rdy4 !== 1'b1 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL %s: d11 line=%b ready=%b busy=%b d4 line=%b ready=%b busy=%b want 1 1 0",
                     name, line11, rdy11, busy11, line4, rdy4, busy4);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        v11   = 1'b0;
        v4    = 1'b0;
        msg11 = '0;
        msg4  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_held");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset_released");
    endtask

    task automatic test_frames_11();
        run_frame(1'b0, 11'h000, 11'h5A5, 1'b0, 15'h0000, 1'b0, "d11_msg000");
        run_frame(1'b0, 11'h001, 11'h7FF, 1'b0, 15'h0007, 1'b1, "d11_msg001");
        run_frame(1'b0, 11'h7FF, 11'h000, 1'b0, 15'h7FFF, 1'b1, "d11_msg7FF");
        run_frame(1'b0, 11'h400, 11'h3C3, 1'b0, 15'h408B, 1'b1, "d11_msg400");
    endtask

    task automatic test_frames_4();
        run_frame(1'b1, 11'h000, 11'h00F, 1'b0, 15'h0000, 1'b0, "d4_msg0");
        run_frame(1'b1, 11'h001, 11'h00E, 1'b0, 15'h0007, 1'b1, "d4_msg1");
        run_frame(1'b1, 11'h00F, 11'h000, 1'b0, 15'h007F, 1'b1, "d4_msgF");
    endtask

    // valid stays high; mid-frame msg change must not alter the frame and becomes the next word after one idle cycle.
    task automatic test_back_to_back();
        run_frame(1'b0, 11'h001, 11'h7FF, 1'b1, 15'h0007, 1'b1, "b2b_first");
        run_frame(1'b0, 11'h7FF, 11'h7FF, 1'b0, 15'h7FFF, 1'b1, "b2b_second");
    endtask

    task automatic test_reset_mid_frame();
        msg11 = 11'h7FF;
        v11   = 1'b1;
        @(posedge clk);
        #1;
        v11 = 1'b0;
        repeat ((1 + 3) * C11) @(negedge clk);
        total++;
        if (busy11 !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_before_reset: got %b want 1", busy11);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (line11 !== 1'b1 || rdy11 !== 1'b1 || busy11 !== 1'b0) begin
            bad++;
            $display("FAIL abort_after_reset: line=%b ready=%b busy=%b want 1 1 0", line11, rdy11, busy11);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(1'b0, 11'h001, 11'h123, 1'b0, 15'h0007, 1'b1, "abort_clean_frame");
    endtask

    initial begin
        test_reset();
        test_frames_11();
        test_frames_4();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
